// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo controller: ALU codes, FSM states and the
// registered control bundle with its per-state decode.
package modulo_pkg;

   localparam int ALU_W = 3;

   localparam logic [ALU_W-1:0] ALU_NOP = 3'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
   localparam logic [ALU_W-1:0] ALU_LTU = 3'd2;

   localparam int          DEF_ALU_LAT  = 2;
   localparam int          DEF_CNT_W    = 16;
   localparam int unsigned DEF_MAX_ITER = 32'h0000_FFFF;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      INIT,
      CMP,
      CMP_WB,
      CHECK,
      SUB,
      SUB_WB,
      DONE,
      ERR
   } state_t;

   typedef struct packed {
      logic [ALU_W-1:0] alu_mode;
      logic             wren_update_zahlen;
      logic             wren_zahl1_to_erg;
      logic             wren_term_erg;
      logic             wren_res_to_erg;
      logic             erg_to_alu_a;
      logic             zahl2_to_alu_b;
      logic             check_for_termination;
      logic             busy;
      logic             done;
      logic             err;
   } ctrl_t;

   // Moore decode: every control depends on the state alone.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c          = '0;
      c.alu_mode = ALU_NOP;
      c.busy     = (s != IDLE);
      case (s)
         LOAD:   c.wren_update_zahlen = 1'b1;
         INIT:   c.wren_zahl1_to_erg  = 1'b1;
         CMP: begin
            c.alu_mode       = ALU_LTU;
            c.erg_to_alu_a   = 1'b1;
            c.zahl2_to_alu_b = 1'b1;
         end
         CMP_WB: c.wren_term_erg = 1'b1;
         CHECK:  c.check_for_termination = 1'b1;
         SUB: begin
            c.alu_mode       = ALU_SUB;
            c.erg_to_alu_a   = 1'b1;
            c.zahl2_to_alu_b = 1'b1;
         end
         SUB_WB: c.wren_res_to_erg = 1'b1;
         DONE:   c.done = 1'b1;
         ERR:    c.err  = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ctrl_modulo.sv
// Controller for the repeated-subtraction modulo datapath: sequences operand
// load, compare, subtract and write-back, and counts iterations (quotient).
module ctrl_modulo
   import modulo_pkg::*;
#(
   parameter int          ALU_LAT  = DEF_ALU_LAT,
   parameter int unsigned MAX_ITER = DEF_MAX_ITER,
   parameter int          CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             valid_i,
   output logic [ALU_W-1:0] alu_mode_o,
   output logic             wren_update_zahlen_o,
   output logic             wren_zahl1_to_erg_o,
   output logic             wren_term_erg_o,
   output logic             wren_res_to_erg_o,
   output logic             erg_to_alu_a_o,
   output logic             zahl2_to_alu_b_o,
   output logic             check_for_termination_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] iter_cnt_o
);

   localparam logic [2:0]       WAIT_INIT  = 3'(ALU_LAT - 1);
   localparam logic [CNT_W-1:0] MAX_ITER_C = CNT_W'(MAX_ITER);

   state_t           r_state;
   ctrl_t            r_ctrl;
   logic [2:0]       r_wait;
   logic [CNT_W-1:0] r_iter;
   state_t           w_state_nxt;
   logic             w_enter_wait;

   // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:   if (start_i) w_state_nxt = LOAD;
         LOAD:   w_state_nxt = INIT;
         INIT:   w_state_nxt = CMP;
         CMP:    if (r_wait == '0) w_state_nxt = CMP_WB;
         CMP_WB: w_state_nxt = CHECK;
         CHECK: begin
            if (valid_i)                   w_state_nxt = DONE;
            else if (r_iter == MAX_ITER_C) w_state_nxt = ERR;
            else                           w_state_nxt = SUB;
         end
         SUB:    if (r_wait == '0) w_state_nxt = SUB_WB;
         SUB_WB: w_state_nxt = CMP;
         DONE:   w_state_nxt = IDLE;
         ERR:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_enter_wait = (w_state_nxt != r_state) &&
                         ((w_state_nxt == CMP) || (w_state_nxt == SUB));

   // NOTE: controls are decoded from the next state so the registered outputs
   // line up with the state they belong to rather than lagging it by a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ctrl  <= '0;
         r_wait  <= '0;
         r_iter  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ctrl  <= ctrl_of(w_state_nxt);

         // Wait counter spans ALU_LAT cycles of CMP or SUB.
         if (w_enter_wait)
            r_wait <= WAIT_INIT;
         else if (r_wait != '0)
            r_wait <= r_wait - 3'd1;

         if (r_state == IDLE && start_i)
            r_iter <= '0;
         else if (r_state == SUB_WB && r_iter != MAX_ITER_C)
            r_iter <= r_iter + CNT_W'(1);
      end
   end

   assign alu_mode_o              = r_ctrl.alu_mode;
   assign wren_update_zahlen_o    = r_ctrl.wren_update_zahlen;
   assign wren_zahl1_to_erg_o     = r_ctrl.wren_zahl1_to_erg;
   assign wren_term_erg_o         = r_ctrl.wren_term_erg;
   assign wren_res_to_erg_o       = r_ctrl.wren_res_to_erg;
   assign erg_to_alu_a_o          = r_ctrl.erg_to_alu_a;
   assign zahl2_to_alu_b_o        = r_ctrl.zahl2_to_alu_b;
   assign check_for_termination_o = r_ctrl.check_for_termination;
   assign busy_o                  = r_ctrl.busy;
   assign done_o                  = r_ctrl.done;
   assign err_o                   = r_ctrl.err;
   assign iter_cnt_o              = r_iter;

endmodule
